pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
Next-generation RV32I control for the 5-stage pipelined core; replaces the single-cycle combinational controller.
- Decodes Op/funct3/funct7 in Decode, then carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Adds load-use stall detection, branch/jump flush, EX-stage forwarding selects, shift/XOR ALU ops, JAL and illegal-opcode flagging.

Parameters:
ALU_CTRL_W, 4, width of ALUControlE; must be 4 or more; upper bits beyond 4 are driven 0.
REG_ADDR_W, 5, register-index width.
HAZARD_EN, 1, 0 ties StallF, StallD, FlushD, FlushE and the Forward selects to 0.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
Op  in  7  opcode of the instruction in D
funct3  in  3  instr[14:12] in D
funct7  in  7  instr[31:25] in D
Rs1D  in  REG_ADDR_W  rs1 index in D
Rs2D  in  REG_ADDR_W  rs2 index in D
RdD  in  REG_ADDR_W  rd index in D
ZeroE  in  1  ALU zero flag, EX stage
ImmSrcD  out  2  immediate select, combinational from D
ALUSrcE  out  1  1 = immediate operand
ALUControlE  out  ALU_CTRL_W  ALU operation
PCSrcE  out  1  take branch/jump target
MemWriteM  out  1  data-memory write
ResultSrcW  out  2  writeback select: 00 ALU, 01 memory, 10 PC+4
RegWriteW  out  1  register-file write
RdW  out  REG_ADDR_W  writeback destination
ForwardAE  out  2  operand-A select: 00 regfile, 01 W, 10 M
ForwardBE  out  2  operand-B select, same encoding as ForwardAE
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
FlushD  out  1  clear IF/ID
FlushE  out  1  bubble ID/EX (internal, also exported)
IllegalE  out  1  unsupported opcode now in EX

Behaviour:
- Decode (combinational; fields are RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump):
  - lw 0000011: 1, 00, 1, 0, 01, 0, 0
  - sw 0100011: 0, 01, 1, 1, 00, 0, 0
  - R-type 0110011: 1, xx, 0, 0, 00, 0, 0
  - I-ALU 0010011: 1, 00, 1, 0, 00, 0, 0
  - beq 1100011: 0, 10, 0, 0, 00, 1, 0
  - jal 1101111: 1, 11, x, 0, 10, 0, 1
  - any other opcode: all enables 0 and Illegal=1.
- ALUControl codes:
  - 0000 add (loads, stores, jal, addi, add)
  - 0001 sub (beq; R-type with funct7[5]=1)
  - 0010 and, 0011 or, 0100 xor, 0101 slt
  - 0110 sll, 0111 srl, 1000 sra (srl vs sra by funct7[5])
  - I-type ignores funct7[5] except on shifts.
  - Unsupported funct3/funct7 combinations decode to add with RegWrite forced 0.
- ID/EX register captures the bundle plus Rs1, Rs2 and Rd.
  - Cleared to all-zero on rst or FlushE.
  - EX/MEM and MEM/WB load every cycle.
  - RegWrite, MemWrite, Branch, Jump and Illegal are 0 after reset, so the pipeline starts as bubbles.
- PCSrcE = (BranchE & ZeroE) | JumpE; combinational from ID/EX state.
- Load-use hazard:
  - Condition: ResultSrcE==01, RegWriteE=1, RdE!=0, and RdE equals Rs1D or Rs2D.
  - Response: StallF=StallD=1 and FlushE=1 for exactly 1 cycle.
- Control hazard: PCSrcE=1 forces FlushD=1 and FlushE=1.
  - Precedence: flush wins; PCSrcE masks StallF/StallD in the same cycle.
- Forwarding, priority M over W:
  - ForwardAE=10 if RegWriteM, RdM!=0 and RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW, RdW!=0 and RdW==Rs1E.
  - Otherwise 00. ForwardBE is identical using Rs2E.
  - Rd=x0 never forwards.
- Reset asserted mid-stream: every pipeline register clears immediately (asynchronous); all outputs read 0 on the next observation.
- Latency: Decode to ALUControlE 1 cycle; to MemWriteM 2 cycles; to RegWriteW/ResultSrcW 3 cycles.

Test Plan:
- Reset: hold rst over 3 edges with an R-type add in D -> RegWriteW=0, PCSrcE=0, ALUControlE=0; first add reaches RegWriteW=1 three edges after rst falls.
- ALU decode: feed sub, xor, sra, slli, slt -> ALUControlE = 0001, 0100, 1000, 0110, 0101 one cycle later; Illegal=0 for all.
- Load-use: lw x5 followed by add x6,x5,x1 -> one cycle of StallF=StallD=FlushE=1; add reaches EX one cycle late; ForwardAE=01 when the add is in EX.
- Back-to-back ALU: add x3,.. then sub x4,x3,x3 -> ForwardAE=ForwardBE=10 in sub's EX cycle; writes to x0 never forward.
- Branch: beq with ZeroE=1 -> PCSrcE=1, FlushD=FlushE=1 same cycle; a coincident load-use stall is suppressed; ZeroE=0 gives no flush.
- Illegal/jal: opcode 0000000 -> IllegalE=1 and nothing written; jal x1 -> PCSrcE=1, later ResultSrcW=10 with RdW=1.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// RV32I pipelined control: decodes in D, carries the control bundle through ID/EX, EX/MEM
// and MEM/WB, and resolves load-use stalls, branch/jump flushes and EX-stage forwarding.
module pipelined_control_unit #(
    parameter int ALU_CTRL_W = 4,
    parameter int REG_ADDR_W = 5,
    parameter int HAZARD_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            Op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  ZeroE,
    output logic [1:0]            ImmSrcD,
    output logic                  ALUSrcE,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic                  PCSrcE,
    output logic                  MemWriteM,
    output logic [1:0]            ResultSrcW,
    output logic                  RegWriteW,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  IllegalE
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam bit         HZ       = (HAZARD_EN != 0);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_op_t;

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  alu_src;
        logic                  illegal;
        alu_op_t               alu_ctrl;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } ctrl_t;

    logic    is_r;
    logic    f7_zero;
    logic    f7_alt;
    logic    alu_ok;
    alu_op_t alu_base;
    ctrl_t   dec;
    ctrl_t   ex;

    logic                  reg_write_m;
    logic [1:0]            result_src_m;
    logic [REG_ADDR_W-1:0] rd_m;
    logic                  load_use;

    assign is_r    = (Op == OP_R);
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    // funct7 only qualifies R-type ops and immediate shifts; elsewhere in I-type it is immediate bits.
    always_comb begin
        alu_base = ALU_ADD;
        alu_ok   = 1'b1;
        case (funct3)
            3'b000: begin
                alu_base = (is_r && f7_alt) ? ALU_SUB : ALU_ADD;
                alu_ok   = !is_r || f7_zero || f7_alt;
            end
            3'b001: begin alu_base = ALU_SLL; alu_ok = f7_zero;          end
            3'b010: begin alu_base = ALU_SLT; alu_ok = !is_r || f7_zero; end
            3'b011: begin alu_base = ALU_ADD; alu_ok = 1'b0;             end
            3'b100: begin alu_base = ALU_XOR; alu_ok = !is_r || f7_zero; end
            3'b101: begin
                alu_base = f7_alt ? ALU_SRA : ALU_SRL;
                alu_ok   = f7_zero || f7_alt;
            end
            3'b110: begin alu_base = ALU_OR;  alu_ok = !is_r || f7_zero; end
            default: begin alu_base = ALU_AND; alu_ok = !is_r || f7_zero; end
        endcase
    end

    always_comb begin
        dec     = '0;
        ImmSrcD = 2'b00;
        dec.rs1 = Rs1D;
        dec.rs2 = Rs2D;
        dec.rd  = RdD;
        case (Op)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
            end
            OP_STORE: begin
                ImmSrcD       = 2'b01;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_R, OP_I: begin
                dec.reg_write = alu_ok;
                dec.alu_src   = !is_r;
                dec.alu_ctrl  = alu_ok ? alu_base : ALU_ADD;
            end
            OP_BEQ: begin
                ImmSrcD      = 2'b10;
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
            end
            OP_JAL: begin
                ImmSrcD        = 2'b11;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // A flushed ID/EX entry is an all-zero bubble: no writes, no branch, no forwarding source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex <= '0;
        end else if (FlushE) begin
            ex <= '0;
        end else begin
            ex <= dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            MemWriteM    <= 1'b0;
            rd_m         <= '0;
            RegWriteW    <= 1'b0;
            ResultSrcW   <= 2'b00;
            RdW          <= '0;
        end else begin
            reg_write_m  <= ex.reg_write;
            result_src_m <= ex.result_src;
            MemWriteM    <= ex.mem_write;
            rd_m         <= ex.rd;
            RegWriteW    <= reg_write_m;
            ResultSrcW   <= result_src_m;
            RdW          <= rd_m;
        end
    end

    assign ALUSrcE  = ex.alu_src;
    assign IllegalE = ex.illegal;
    assign PCSrcE   = (ex.branch & ZeroE) | ex.jump;

    always_comb begin
        ALUControlE      = '0;
        ALUControlE[3:0] = ex.alu_ctrl;
    end

    assign load_use = (ex.result_src == 2'b01) && ex.reg_write && (ex.rd != '0)
                      && ((ex.rd == Rs1D) || (ex.rd == Rs2D));

    // A taken branch/jump discards the stalled instruction anyway, so the flush masks the stall.
    assign StallF = HZ && load_use && !PCSrcE;
    assign StallD = HZ && load_use && !PCSrcE;
    assign FlushD = HZ && PCSrcE;
    assign FlushE = HZ && (load_use || PCSrcE);

    assign ForwardAE = !HZ ? 2'b00 :
                       (reg_write_m && (rd_m != '0) && (rd_m == ex.rs1)) ? 2'b10 :
                       (RegWriteW && (RdW != '0) && (RdW == ex.rs1))     ? 2'b01 : 2'b00;
    assign ForwardBE = !HZ ? 2'b00 :
                       (reg_write_m && (rd_m != '0) && (rd_m == ex.rs2)) ? 2'b10 :
                       (RegWriteW && (RdW != '0) && (RdW == ex.rs2))     ? 2'b01 : 2'b00;

    logic unused_src_m;
    assign unused_src_m = ^result_src_m;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed scenarios plus a randomized run checked against
// an instruction-level model of the five-stage pipeline.
module tb_pipelined_control_unit;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] F7A  = 7'b0100000;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       ZeroE;
    logic [1:0] ImmSrcD;
    logic       ALUSrcE;
    logic [3:0] ALUControlE;
    logic       PCSrcE, MemWriteM;
    logic [1:0] ResultSrcW;
    logic       RegWriteW;
    logic [4:0] RdW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, FlushD, FlushE, IllegalE;

    int checks = 0;
    int failures = 0;

    pipelined_control_unit dut (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
        .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .PCSrcE(PCSrcE),
        .MemWriteM(MemWriteM), .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW), .RdW(RdW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .IllegalE(IllegalE)
    );

    always #5 clk = ~clk;

    // Instruction record as the architecture describes it; one per pipeline stage.
    typedef struct packed {
        logic       rw;
        logic [1:0] imm;
        logic       alu_src;
        logic       mw;
        logic [1:0] res;
        logic       br;
        logic       jp;
        logic       ill;
        logic [3:0] alu;
        logic [4:0] rs1, rs2, rd;
    } ins_t;

    ins_t d, ex, mem, wb;
    logic cur_z;

    function automatic logic [3:0] alu_of(input logic is_r, input logic [2:0] f3,
                                          input logic [6:0] f7, output logic ok);
        logic alt, z;
        alt = (f7 == F7A);
        z   = (f7 == 7'd0);
        case (f3)
            3'd0: begin alu_of = (is_r && alt) ? 4'd1 : 4'd0; ok = !is_r || z || alt; end
            3'd1: begin alu_of = 4'd6; ok = z; end
            3'd2: begin alu_of = 4'd5; ok = !is_r || z; end
            3'd3: begin alu_of = 4'd0; ok = 1'b0; end
            3'd4: begin alu_of = 4'd4; ok = !is_r || z; end
            3'd5: begin alu_of = alt ? 4'd8 : 4'd7; ok = z || alt; end
            3'd6: begin alu_of = 4'd3; ok = !is_r || z; end
            default: begin alu_of = 4'd2; ok = !is_r || z; end
        endcase
    endfunction

    function automatic ins_t decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ins_t r;
        logic ok;
        r = '0;
        r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        case (op)
            LW:  begin r.rw = 1; r.alu_src = 1; r.res = 2'b01; end
            SW:  begin r.imm = 2'b01; r.alu_src = 1; r.mw = 1; end
            RT, IT: begin
                r.alu = alu_of(op == RT, f3, f7, ok);
                r.alu_src = (op == IT);
                r.rw = ok;
                if (!ok) r.alu = 4'd0;
            end
            BEQ: begin r.imm = 2'b10; r.br = 1; r.alu = 4'd1; end
            JAL: begin r.rw = 1; r.imm = 2'b11; r.res = 2'b10; r.jp = 1; end
            default: r.ill = 1;
        endcase
        return r;
    endfunction

    function automatic logic exp_pcsrc();
        return (ex.br & cur_z) | ex.jp;
    endfunction

    function automatic logic exp_load_use();
        return (ex.res == 2'b01) && ex.rw && (ex.rd != 0) && ((ex.rd == d.rs1) || (ex.rd == d.rs2));
    endfunction

    function automatic logic exp_stall();
        return exp_load_use() && !exp_pcsrc();
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (mem.rw && mem.rd != 0 && mem.rd == rs) return 2'b10;
        if (wb.rw && wb.rd != 0 && wb.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Advance one clock: model moves instructions a stage forward, then new D inputs are applied.
    task automatic cycle(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic z);
        logic fl_e;
        fl_e = exp_load_use() || exp_pcsrc();
        @(posedge clk);
        if (rst) begin
            ex = '0; mem = '0; wb = '0;
        end else begin
            wb = mem; mem = ex; ex = fl_e ? '0 : d;
        end
        #1;
        Op = op; funct3 = f3; funct7 = f7; RdD = rd; Rs1D = rs1; Rs2D = rs2; ZeroE = z;
        cur_z = z;
        d = decode(op, f3, f7, rd, rs1, rs2);
        #1;
    endtask

    task automatic nop(input logic z = 1'b0);
        cycle(IT, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, z);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cycle(RT, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 1'b0);
        checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL rst_regwrite got=%b exp=0", RegWriteW); end
        checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL rst_pcsrc got=%b exp=0", PCSrcE); end
        checks++; if (ALUControlE !== 4'd0) begin failures++; $display("FAIL rst_aluctrl got=%h exp=0", ALUControlE); end
        checks++; if ({StallF, FlushE, ForwardAE, IllegalE} !== 5'd0) begin failures++; $display("FAIL rst_hazard got=%b exp=0", {StallF, FlushE, ForwardAE, IllegalE}); end
        rst = 1'b0;
        repeat (2) cycle(RT, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 1'b0);
        checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL rst_lat2 got=%b exp=0", RegWriteW); end
        cycle(RT, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 1'b0);
        checks++; if ({RegWriteW, RdW, ResultSrcW} !== {1'b1, 5'd3, 2'b00}) begin failures++; $display("FAIL rst_lat3 got=%b_%0d_%b exp=1_3_00", RegWriteW, RdW, ResultSrcW); end
        cycle(SW, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 1'b0);
        nop(); nop();
        checks++; if (MemWriteM !== 1'b1) begin failures++; $display("FAIL sw_memwrite got=%b exp=1", MemWriteM); end
        #3 rst = 1'b1;
        #1;
        checks++; if ({MemWriteM, RegWriteW, RdW, ALUSrcE, ResultSrcW} !== 10'd0) begin failures++; $display("FAIL async_rst got=%b exp=0", {MemWriteM, RegWriteW, RdW, ALUSrcE, ResultSrcW}); end
        ex = '0; mem = '0; wb = '0;
        nop();
        rst = 1'b0;
        nop(); nop(); nop();
    endtask

    task automatic test_alu_decode();
        logic [6:0] ops [5];
        logic [2:0] f3s [5];
        logic [6:0] f7s [5];
        logic [3:0] exp [5];
        ops = '{RT, RT, RT, IT, RT};
        f3s = '{3'd0, 3'd4, 3'd5, 3'd1, 3'd2};
        f7s = '{F7A, 7'd0, F7A, 7'd0, 7'd0};
        exp = '{4'd1, 4'd4, 4'd8, 4'd6, 4'd5};
        for (int i = 0; i < 5; i++) begin
            cycle(ops[i], f3s[i], f7s[i], 5'(10 + i), 5'd1, 5'd2, 1'b0);
            if (i > 0) begin
                checks++; if ({ALUControlE, IllegalE} !== {exp[i-1], 1'b0}) begin failures++; $display("FAIL alu_dec%0d got=%h/%b exp=%h/0", i - 1, ALUControlE, IllegalE, exp[i-1]); end
            end
        end
        cycle(IT, 3'd4, F7A, 5'd9, 5'd1, 5'd0, 1'b0);
        checks++; if ({ALUControlE, IllegalE, ALUSrcE} !== {4'd5, 1'b0, 1'b0}) begin failures++; $display("FAIL alu_dec4 got=%h/%b/%b exp=5/0/0", ALUControlE, IllegalE, ALUSrcE); end
        nop();
        checks++; if ({ALUControlE, ALUSrcE} !== {4'd4, 1'b1}) begin failures++; $display("FAIL xori_f7 got=%h/%b exp=4/1", ALUControlE, ALUSrcE); end
        cycle(RT, 3'd3, 7'd0, 5'd7, 5'd1, 5'd2, 1'b0);
        nop(); nop(); nop();
        checks++; if ({RegWriteW, RdW} !== {1'b0, 5'd7}) begin failures++; $display("FAIL unsup_rw got=%b/%0d exp=0/7", RegWriteW, RdW); end
    endtask

    task automatic test_load_use();
        nop(); nop();
        cycle(LW, 3'd2, 7'd0, 5'd5, 5'd1, 5'd0, 1'b0);
        cycle(RT, 3'd0, 7'd0, 5'd6, 5'd5, 5'd1, 1'b0);
        checks++; if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin failures++; $display("FAIL lu_stall got=%b exp=1110", {StallF, StallD, FlushE, FlushD}); end
        cycle(RT, 3'd0, 7'd0, 5'd6, 5'd5, 5'd1, 1'b0);
        checks++; if ({StallF, StallD, FlushE, ForwardAE} !== 5'b00000) begin failures++; $display("FAIL lu_once got=%b exp=00000", {StallF, StallD, FlushE, ForwardAE}); end
        nop();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0100) begin failures++; $display("FAIL lu_fwd got=%b exp=0100", {ForwardAE, ForwardBE}); end
        checks++; if ({RegWriteW, ResultSrcW, RdW} !== {1'b1, 2'b01, 5'd5}) begin failures++; $display("FAIL lu_wb got=%b_%b_%0d exp=1_01_5", RegWriteW, ResultSrcW, RdW); end
    endtask

    task automatic test_back_to_back();
        nop(); nop();
        cycle(RT, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 1'b0);
        cycle(RT, 3'd0, F7A, 5'd4, 5'd3, 5'd3, 1'b0);
        nop();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b1010) begin failures++; $display("FAIL b2b_mem got=%b exp=1010", {ForwardAE, ForwardBE}); end
        cycle(RT, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 1'b0);
        cycle(RT, 3'd0, F7A, 5'd4, 5'd0, 5'd0, 1'b0);
        nop();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin failures++; $display("FAIL b2b_x0 got=%b exp=0000", {ForwardAE, ForwardBE}); end
        cycle(RT, 3'd0, 7'd0, 5'd7, 5'd1, 5'd2, 1'b0);
        nop();
        cycle(RT, 3'd0, F7A, 5'd8, 5'd7, 5'd1, 1'b0);
        nop();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0100) begin failures++; $display("FAIL b2b_wb got=%b exp=0100", {ForwardAE, ForwardBE}); end
        cycle(RT, 3'd0, 7'd0, 5'd9, 5'd1, 5'd2, 1'b0);
        cycle(RT, 3'd6, 7'd0, 5'd9, 5'd1, 5'd2, 1'b0);
        cycle(RT, 3'd0, F7A, 5'd10, 5'd9, 5'd9, 1'b0);
        nop();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b1010) begin failures++; $display("FAIL b2b_prio got=%b exp=1010", {ForwardAE, ForwardBE}); end
    endtask

    task automatic test_branch();
        nop(); nop();
        cycle(BEQ, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 1'b0);
        cycle(RT, 3'd0, 7'd0, 5'd6, 5'd5, 5'd1, 1'b1);
        checks++; if ({PCSrcE, FlushD, FlushE, StallF, StallD} !== 5'b11100) begin failures++; $display("FAIL br_taken got=%b exp=11100", {PCSrcE, FlushD, FlushE, StallF, StallD}); end
        nop(1'b1);
        checks++; if ({PCSrcE, FlushD, FlushE} !== 3'b000) begin failures++; $display("FAIL br_bubble got=%b exp=000", {PCSrcE, FlushD, FlushE}); end
        cycle(BEQ, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 1'b0);
        nop(1'b0);
        checks++; if ({PCSrcE, FlushD, FlushE, ALUControlE} !== {3'b000, 4'd1}) begin failures++; $display("FAIL br_not got=%b exp=0000001", {PCSrcE, FlushD, FlushE, ALUControlE}); end
    endtask

    task automatic test_illegal_jal();
        nop(); nop();
        cycle(7'b0000000, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 1'b0);
        nop();
        checks++; if ({IllegalE, ALUControlE} !== {1'b1, 4'd0}) begin failures++; $display("FAIL ill_e got=%b exp=10000", {IllegalE, ALUControlE}); end
        nop();
        checks++; if ({IllegalE, MemWriteM} !== 2'b00) begin failures++; $display("FAIL ill_m got=%b exp=00", {IllegalE, MemWriteM}); end
        nop();
        checks++; if ({RegWriteW, RdW} !== {1'b0, 5'd7}) begin failures++; $display("FAIL ill_w got=%b/%0d exp=0/7", RegWriteW, RdW); end
        cycle(JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 1'b0);
        checks++; if (ImmSrcD !== 2'b11) begin failures++; $display("FAIL jal_imm got=%b exp=11", ImmSrcD); end
        nop();
        checks++; if ({PCSrcE, FlushD, FlushE} !== 3'b111) begin failures++; $display("FAIL jal_pcsrc got=%b exp=111", {PCSrcE, FlushD, FlushE}); end
        nop(); nop();
        checks++; if ({RegWriteW, ResultSrcW, RdW} !== {1'b1, 2'b10, 5'd1}) begin failures++; $display("FAIL jal_wb got=%b_%b_%0d exp=1_10_1", RegWriteW, ResultSrcW, RdW); end
    endtask

    task automatic test_random();
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        logic z;
        int k;
        op = IT; f3 = 0; f7 = 0; rd = 0; rs1 = 0; rs2 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!exp_stall()) begin
                k = $urandom_range(0, 7);
                f3 = 3'($urandom_range(0, 7));
                f7 = ($urandom_range(0, 3) == 0) ? F7A : 7'd0;
                rd = 5'($urandom_range(0, 3));
                rs1 = 5'($urandom_range(0, 3));
                rs2 = 5'($urandom_range(0, 3));
                case (k)
                    0: op = LW;
                    1: op = SW;
                    2: op = RT;
                    3: begin op = RT; f7 = 7'($urandom_range(0, 127)); end
                    4: op = IT;
                    5: op = BEQ;
                    6: op = JAL;
                    default: op = ($urandom_range(0, 1) == 1) ? 7'b0000000 : 7'b1110011;
                endcase
            end
            z = 1'($urandom_range(0, 1));
            cycle(op, f3, f7, rd, rs1, rs2, z);
            if (op != RT) begin
                checks++; if (ImmSrcD !== d.imm) begin failures++; $display("FAIL rnd_imm n=%0d got=%b exp=%b", n, ImmSrcD, d.imm); end
            end
            if (!ex.jp) begin
                checks++; if (ALUSrcE !== ex.alu_src) begin failures++; $display("FAIL rnd_alusrc n=%0d got=%b exp=%b", n, ALUSrcE, ex.alu_src); end
            end
            checks++; if (ALUControlE !== ex.alu) begin failures++; $display("FAIL rnd_aluctrl n=%0d got=%h exp=%h", n, ALUControlE, ex.alu); end
            checks++; if (IllegalE !== ex.ill) begin failures++; $display("FAIL rnd_illegal n=%0d got=%b exp=%b", n, IllegalE, ex.ill); end
            checks++; if (PCSrcE !== exp_pcsrc()) begin failures++; $display("FAIL rnd_pcsrc n=%0d got=%b exp=%b", n, PCSrcE, exp_pcsrc()); end
            checks++; if (MemWriteM !== mem.mw) begin failures++; $display("FAIL rnd_memwrite n=%0d got=%b exp=%b", n, MemWriteM, mem.mw); end
            checks++; if ({RegWriteW, ResultSrcW, RdW} !== {wb.rw, wb.res, wb.rd}) begin failures++; $display("FAIL rnd_wb n=%0d got=%b exp=%b", n, {RegWriteW, ResultSrcW, RdW}, {wb.rw, wb.res, wb.rd}); end
            checks++; if (ForwardAE !== exp_fwd(ex.rs1)) begin failures++; $display("FAIL rnd_fwda n=%0d got=%b exp=%b", n, ForwardAE, exp_fwd(ex.rs1)); end
            checks++; if (ForwardBE !== exp_fwd(ex.rs2)) begin failures++; $display("FAIL rnd_fwdb n=%0d got=%b exp=%b", n, ForwardBE, exp_fwd(ex.rs2)); end
            checks++; if ({StallF, StallD} !== {2{exp_stall()}}) begin failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, {StallF, StallD}, exp_stall()); end
            checks++; if ({FlushD, FlushE} !== {exp_pcsrc(), exp_load_use() || exp_pcsrc()}) begin failures++; $display("FAIL rnd_flush n=%0d got=%b exp=%b", n, {FlushD, FlushE}, {exp_pcsrc(), exp_load_use() || exp_pcsrc()}); end
        end
    endtask

    initial begin
        rst = 1'b1;
        Op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0; ZeroE = 1'b0;
        cur_z = 1'b0;
        d = decode(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
        ex = '0; mem = '0; wb = '0;
        test_reset();
        test_alu_decode();
        test_load_use();
        test_back_to_back();
        test_branch();
        test_illegal_jal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
